// File: rtl/ad9361_sync_fifo.sv
// ----------------------------------------------------------------------------
// ad9361_sync_fifo
//
// Single-clock FIFO built on a DEPTH-entry circular buffer. The occupancy
// counter and all status flags are registered and change on the same edge.
// Overflow and underflow attempts produce one-cycle error pulses.
//
// Parameters:
//   DATA_WIDTH          word width
//   ADDR_WIDTH          log2 of storage depth (DEPTH = 2**ADDR_WIDTH)
//   ALMOST_EMPTY_OFFSET almost_empty asserted while count <= this value
//   ALMOST_FULL_OFFSET  almost_full asserted while count >= DEPTH - this value
//   FWFT                1: rd_data shows the head word with no read latency
//                       0: rd_data is loaded on an accepted read (1 cycle)
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   wr_data, wr_en      write port
//   rd_en, rd_data      read port
//   empty, almost_empty, full, almost_full, count   registered status
//   wr_err, rd_err      one-cycle pulses after a rejected write / read
//
// Handshake: a write is accepted on an edge where wr_en=1 and full=0; a read
// is accepted on an edge where rd_en=1 and empty=0. full/empty act as the
// ready signals, wr_en/rd_en as the valids. A request that is not accepted
// is dropped (not held) and reported on wr_err/rd_err the following cycle.
// ----------------------------------------------------------------------------
module ad9361_sync_fifo #(
    parameter int DATA_WIDTH          = 32,
    parameter int ADDR_WIDTH          = 9,
    parameter int ALMOST_EMPTY_OFFSET = 128,
    parameter int ALMOST_FULL_OFFSET  = 128,
    parameter int FWFT                = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  wr_err,
    output logic                  rd_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AE_TH   = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_OFFSET);
    localparam logic [ADDR_WIDTH:0] AF_TH   = (ADDR_WIDTH + 1)'(DEPTH - ALMOST_FULL_OFFSET);

    if (ALMOST_EMPTY_OFFSET >= DEPTH || ALMOST_FULL_OFFSET >= DEPTH) begin : g_bad_params
        $error("ad9361_sync_fifo: almost offsets must be smaller than DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  almost_empty_q, almost_empty_d;
    logic                  almost_full_q, almost_full_d;
    logic                  wr_err_q, wr_err_d;
    logic                  rd_err_q, rd_err_d;

    logic wr_acc;
    logic rd_acc;

    // At full only the read can go; at empty only the write can go.
    assign wr_acc = wr_en && !full_q;
    assign rd_acc = rd_en && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + (ADDR_WIDTH + 1)'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - (ADDR_WIDTH + 1)'(1);
        end

        // Flags derive from the next count so they move together with it.
        empty_d        = (count_d == '0);
        full_d         = (count_d == DEPTH_C);
        almost_empty_d = (count_d <= AE_TH);
        almost_full_d  = (count_d >= AF_TH);

        wr_err_d = wr_en && !wr_acc;
        rd_err_d = rd_en && !rd_acc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= 1'b1;
            almost_full_q  <= 1'b0;
            wr_err_q       <= 1'b0;
            rd_err_q       <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            empty_q        <= empty_d;
            full_q         <= full_d;
            almost_empty_q <= almost_empty_d;
            almost_full_q  <= almost_full_d;
            wr_err_q       <= wr_err_d;
            rd_err_q       <= rd_err_d;
        end
    end

    // Storage is not cleared by reset; emptying the pointers discards it.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is always on the output; meaningless while empty.
        assign rd_data = mem[rd_ptr_q];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

        // Memory is only addressed on an accepted read, never while empty.
        always_comb begin
            rd_data_d = rd_data_q;
            if (rd_acc) begin
                rd_data_d = mem[rd_ptr_q];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_data_q <= '0;
            end else begin
                rd_data_q <= rd_data_d;
            end
        end

        assign rd_data = rd_data_q;
    end

    assign empty        = empty_q;
    assign almost_empty = almost_empty_q;
    assign full         = full_q;
    assign almost_full  = almost_full_q;
    assign count        = count_q;
    assign wr_err       = wr_err_q;
    assign rd_err       = rd_err_q;

endmodule

// File: tb/tb_ad9361_sync_fifo.sv
module tb_ad9361_sync_fifo;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int OFF   = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset   = 1'b1;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;

    // FWFT instance
    logic [DW-1:0] rd_data_f;
    logic          empty_f, almost_empty_f, full_f, almost_full_f, wr_err_f, rd_err_f;
    logic [AW:0]   count_f;

    // standard-read instance, same stimulus
    logic [DW-1:0] rd_data_s;
    logic          empty_s, almost_empty_s, full_s, almost_full_s, wr_err_s, rd_err_s;
    logic [AW:0]   count_s;

    ad9361_sync_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .ALMOST_EMPTY_OFFSET(OFF), .ALMOST_FULL_OFFSET(OFF), .FWFT(1)
    ) u_dut (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
        .rd_data(rd_data_f), .empty(empty_f), .almost_empty(almost_empty_f),
        .full(full_f), .almost_full(almost_full_f), .count(count_f),
        .wr_err(wr_err_f), .rd_err(rd_err_f)
    );

    ad9361_sync_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .ALMOST_EMPTY_OFFSET(OFF), .ALMOST_FULL_OFFSET(OFF), .FWFT(0)
    ) u_dut_std (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
        .rd_data(rd_data_s), .empty(empty_s), .almost_empty(almost_empty_s),
        .full(full_s), .almost_full(almost_full_s), .count(count_s),
        .wr_err(wr_err_s), .rd_err(rd_err_s)
    );

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_rd = '0;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle of stimulus; expectations come from the queue model.
    task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic rd);
        logic full_m, empty_m, wa, ra;
        int   n;
        reset   = 1'b0;
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        #1;
        full_m  = (exp_q.size() == DEPTH);
        empty_m = (exp_q.size() == 0);
        wa      = wr && !full_m;
        ra      = rd && !empty_m;
        if (!empty_m) check("fwft_head", rd_data_f, exp_q[0]);
        @(posedge clk);
        if (ra) last_rd = exp_q.pop_front();
        if (wa) exp_q.push_back(d);
        #1;
        n = exp_q.size();
        check("count",        DW'(count_f),        DW'(n));
        check("count_std",    DW'(count_s),        DW'(n));
        check("empty",        DW'(empty_f),        DW'(n == 0));
        check("full",         DW'(full_f),         DW'(n == DEPTH));
        check("almost_empty", DW'(almost_empty_f), DW'(n <= OFF));
        check("almost_full",  DW'(almost_full_f),  DW'(n >= DEPTH - OFF));
        check("wr_err",       DW'(wr_err_f),       DW'(wr && !wa));
        check("rd_err",       DW'(rd_err_f),       DW'(rd && !ra));
        check("std_rd_data",  rd_data_s,           last_rd);
    endtask

    // Reset pulse with a write request present: nothing may be stored.
    task automatic pulse_reset();
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        rd_en   = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        last_rd = '0;
        check("rst_count",  DW'(count_f),        32'd0);
        check("rst_empty",  DW'(empty_f),        32'd1);
        check("rst_aempty", DW'(almost_empty_f), 32'd1);
        check("rst_full",   DW'(full_f),         32'd0);
        check("rst_afull",  DW'(almost_full_f),  32'd0);
        check("rst_wr_err", DW'(wr_err_f),       32'd0);
        check("rst_rd_err", DW'(rd_err_f),       32'd0);
        check("rst_std_rd", rd_data_s,           32'd0);
        reset = 1'b0;
        wr_en = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        repeat (2) @(posedge clk);
        pulse_reset();

        // fill 0..15
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0);
        check("fill_count", DW'(count_f), 32'd16);
        check("fill_full",  DW'(full_f),  32'd1);

        // overflow: 17th write rejected
        cycle(1'b1, 32'h99, 1'b0);
        check("ovf_wr_err", DW'(wr_err_f), 32'd1);
        check("ovf_count",  DW'(count_f),  32'd16);
        cycle(1'b0, 32'h0, 1'b0);
        check("ovf_pulse_end", DW'(wr_err_f), 32'd0);

        // simultaneous at full: oldest word (0) leaves, write rejected
        check("full_head", rd_data_f, 32'd0);
        cycle(1'b1, 32'h100, 1'b1);
        check("full_both_wr_err", DW'(wr_err_f), 32'd1);
        check("full_both_count",  DW'(count_f),  32'd15);
        check("full_both_std",    rd_data_s,     32'd0);

        // drain 1..15 in order
        for (int i = 1; i < DEPTH; i++) begin
            check("drain_order", rd_data_f, DW'(i));
            cycle(1'b0, 32'h0, 1'b1);
        end
        check("drain_empty", DW'(empty_f), 32'd1);

        // underflow
        cycle(1'b0, 32'h0, 1'b1);
        check("unf_rd_err", DW'(rd_err_f), 32'd1);
        check("unf_count",  DW'(count_f),  32'd0);

        // simultaneous at empty: write goes in, read rejected
        cycle(1'b1, 32'h55, 1'b1);
        check("empty_both_count",  DW'(count_f),  32'd1);
        check("empty_both_rd_err", DW'(rd_err_f), 32'd1);
        check("empty_both_head",   rd_data_f,     32'h55);

        // up to 8, then simultaneous at 8
        for (int i = 0; i < 7; i++) cycle(1'b1, 32'hB000_0000 + DW'(i), 1'b0);
        cycle(1'b1, 32'hB000_0100, 1'b1);
        check("mid_both_count", DW'(count_f), 32'd8);

        // wrap-around: settle at 5, then 40 interleaved cycles within 5..7
        repeat (3) cycle(1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 40; k++) begin
            if ((k % 8) < 4) cycle(1'b1, 32'hC000_0000 + DW'(k), (k % 2) == 1);
            else             cycle((k % 2) == 1, 32'hC000_0000 + DW'(k), 1'b1);
        end
        while (exp_q.size() > 0) cycle(1'b0, 32'h0, 1'b1);

        // standard-read latency and hold
        pulse_reset();
        cycle(1'b1, 32'hA5A5_A5A5, 1'b0);
        check("std_no_read_yet", rd_data_s, 32'd0);
        cycle(1'b0, 32'h0, 1'b1);
        check("std_latency", rd_data_s, 32'hA5A5_A5A5);
        cycle(1'b0, 32'h0, 1'b0);
        check("std_hold", rd_data_s, 32'hA5A5_A5A5);
        cycle(1'b0, 32'h0, 1'b1);
        check("std_hold_rej", rd_data_s, 32'hA5A5_A5A5);

        // reset mid-operation at count 7
        for (int i = 0; i < 7; i++) cycle(1'b1, 32'hD000_0000 + DW'(i), 1'b0);
        check("pre_rst_count", DW'(count_f), 32'd7);
        pulse_reset();
        cycle(1'b1, 32'h1234_5678, 1'b0);
        check("post_rst_head", rd_data_f, 32'h1234_5678);
        cycle(1'b0, 32'h0, 1'b1);
        check("post_rst_std", rd_data_s, 32'h1234_5678);
        check("post_rst_empty", DW'(empty_f), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
